// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the system bus arbiter.
package bus_arbiter_pkg;

  localparam int unsigned DEFAULT_TIMEOUT = 256;
  localparam int unsigned NUM_MASTERS     = 32;
  localparam int unsigned IDX_W           = 5;
  localparam int unsigned WD_W            = 16;

  // Address bits [31:30] of the memory region the caches snoop.
  localparam logic [1:0] SNOOP_REGION = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_GRANT      = 3'd1,
    ST_WAIT_BEGIN = 3'd2,
    ST_BUSY       = 3'd3,
    ST_ERROR      = 3'd4,
    ST_END        = 3'd5
  } arb_state_t;

  function automatic logic [NUM_MASTERS-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return {{(NUM_MASTERS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/bus_arbiter_prio_enc.sv
// Fixed-priority encoder: the highest set request index wins.
module bus_arbiter_prio_enc
  import bus_arbiter_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] i_req,
  output logic                   o_valid,
  output logic [IDX_W-1:0]       o_index
);

  // Scan upward so the last (highest) set bit overwrites lower ones.
  always_comb begin
    o_valid = |i_req;
    o_index = '0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      if (i_req[i]) o_index = IDX_W'(i);
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Central arbiter for the shared system bus: fixed-priority one-cycle
// grant, transaction tracking, and a stall watchdog that aborts a
// transaction with bus error followed by end-of-transaction.
//
//  state         | meaning
//  --------------+------------------------------------------------------
//  ST_IDLE       | bus free, sampling requests
//  ST_GRANT      | one-hot grant driven for this single cycle
//  ST_WAIT_BEGIN | waiting for the granted master to begin (watchdog on)
//  ST_BUSY       | transaction in flight until endTransactionIn
//  ST_ERROR      | watchdog fired, busErrorOut pulsed
//  ST_END        | endTransactionOut pulsed, then back to idle
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] busRequests,
  output logic [NUM_MASTERS-1:0] busGrants,
  input  logic                   beginTransactionIn,
  input  logic                   endTransactionIn,
  input  logic                   dataValidIn,
  input  logic [1:0]             addressDataIn,
  input  logic [7:0]             burstSizeIn,
  output logic                   busErrorOut,
  output logic                   endTransactionOut,
  output logic                   busIdle,
  output logic                   snoopableBurst
);

  // The counter holds TIMEOUT-2 on the last quiet cycle; the next quiet
  // edge would make it TIMEOUT-1, so that edge moves to ST_ERROR instead.
  // With begin sampled at edge E, busErrorOut shows TIMEOUT cycles after
  // the begin cycle.
  localparam logic [WD_W-1:0] WD_FIRE = WD_W'(TIMEOUT - 2);

  logic                   w_req_valid;
  logic [IDX_W-1:0]       w_req_idx;
  logic                   w_wd_clear;
  logic                   w_wd_expire;
  logic                   w_gnt_req;
  logic                   w_snoop_hit;

  arb_state_t             r_state;
  logic [IDX_W-1:0]       r_gnt_idx;
  logic [WD_W-1:0]        r_wd_cnt;
  logic [NUM_MASTERS-1:0] r_grants;
  logic                   r_bus_error;
  logic                   r_end_trans;
  logic                   r_idle;
  logic                   r_snoop;

  bus_arbiter_prio_enc u_prio_enc (
    .i_req   (busRequests),
    .o_valid (w_req_valid),
    .o_index (w_req_idx)
  );

  assign w_wd_clear  = dataValidIn | beginTransactionIn;
  assign w_wd_expire = !w_wd_clear && (r_wd_cnt == WD_FIRE);
  assign w_gnt_req   = busRequests[r_gnt_idx];
  assign w_snoop_hit = (addressDataIn == SNOOP_REGION) && (burstSizeIn != 8'd0);

  // Controller: state, watchdog and all registered outputs in one place.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_gnt_idx   <= '0;
      r_wd_cnt    <= '0;
      r_grants    <= '0;
      r_bus_error <= 1'b0;
      r_end_trans <= 1'b0;
      r_idle      <= 1'b1;
      r_snoop     <= 1'b0;
    end else begin
      r_grants    <= '0;
      r_bus_error <= 1'b0;
      r_end_trans <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req_valid) begin
            r_gnt_idx <= w_req_idx;
            r_grants  <= idx_to_onehot(w_req_idx);
            r_idle    <= 1'b0;
            r_state   <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          r_wd_cnt <= '0;
          r_state  <= ST_WAIT_BEGIN;
        end
        ST_WAIT_BEGIN: begin
          if (beginTransactionIn) begin
            r_wd_cnt <= '0;
            r_snoop  <= w_snoop_hit;
            r_state  <= ST_BUSY;
          end else if (w_wd_expire) begin
            // Watchdog outranks an abandoned request.
            r_wd_cnt    <= '0;
            r_bus_error <= 1'b1;
            r_state     <= ST_ERROR;
          end else if (!w_gnt_req) begin
            r_wd_cnt <= '0;
            r_idle   <= 1'b1;
            r_state  <= ST_IDLE;
          end else begin
            r_wd_cnt <= dataValidIn ? '0 : r_wd_cnt + 1'b1;
          end
        end
        ST_BUSY: begin
          if (endTransactionIn) begin
            // A clean end beats a simultaneous watchdog expiry.
            r_wd_cnt <= '0;
            r_snoop  <= 1'b0;
            r_idle   <= 1'b1;
            r_state  <= ST_IDLE;
          end else if (w_wd_expire) begin
            r_wd_cnt    <= '0;
            r_snoop     <= 1'b0;
            r_bus_error <= 1'b1;
            r_state     <= ST_ERROR;
          end else begin
            r_wd_cnt <= w_wd_clear ? '0 : r_wd_cnt + 1'b1;
          end
        end
        ST_ERROR: begin
          r_end_trans <= 1'b1;
          r_state     <= ST_END;
        end
        ST_END: begin
          r_idle  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_wd_cnt <= '0;
          r_snoop  <= 1'b0;
          r_idle   <= 1'b1;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign busGrants         = r_grants;
  assign busErrorOut       = r_bus_error;
  assign endTransactionOut = r_end_trans;
  assign busIdle           = r_idle;
  assign snoopableBurst    = r_snoop;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus pushes expected output
// events (grant / error / end pulses with their cycle), a monitor pops
// and compares whenever the DUT shows one. Levels are checked inline.
module tb_bus_arbiter;

  localparam int TO = 32;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] busRequests;
  logic [31:0] busGrants;
  logic        beginTransactionIn;
  logic        endTransactionIn;
  logic        dataValidIn;
  logic [1:0]  addressDataIn;
  logic [7:0]  burstSizeIn;
  logic        busErrorOut;
  logic        endTransactionOut;
  logic        busIdle;
  logic        snoopableBurst;

  typedef struct {
    logic [31:0] grants;
    logic        err;
    logic        eot;
    int          cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  int  c, b;

  bus_arbiter #(.TIMEOUT(TO)) dut (
    .clock              (clock),
    .reset              (reset),
    .busRequests        (busRequests),
    .busGrants          (busGrants),
    .beginTransactionIn (beginTransactionIn),
    .endTransactionIn   (endTransactionIn),
    .dataValidIn        (dataValidIn),
    .addressDataIn      (addressDataIn),
    .burstSizeIn        (burstSizeIn),
    .busErrorOut        (busErrorOut),
    .endTransactionOut  (endTransactionOut),
    .busIdle            (busIdle),
    .snoopableBurst     (snoopableBurst)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (cyc %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic push(input logic [31:0] g, input logic er, input logic eo, input int at);
    ev_t e;
    e.grants = g;
    e.err    = er;
    e.eot    = eo;
    e.cyc    = at;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Monitor: every visible pulse must match the next expected event.
  always @(negedge clock) begin
    if (reset === 1'b1 && (busGrants != 32'd0 || busErrorOut || endTransactionOut)) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got grants=%h err=%b eot=%b cyc=%0d, required no event",
                 busGrants, busErrorOut, endTransactionOut, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (busGrants !== mon_e.grants || busErrorOut !== mon_e.err ||
            endTransactionOut !== mon_e.eot || cyc != mon_e.cyc) begin
          n_fail++;
          $display("FAIL event: got grants=%h err=%b eot=%b cyc=%0d, required grants=%h err=%b eot=%b cyc=%0d",
                   busGrants, busErrorOut, endTransactionOut, cyc,
                   mon_e.grants, mon_e.err, mon_e.eot, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    busRequests = '0;
    beginTransactionIn = 1'b0;
    endTransactionIn = 1'b0;
    dataValidIn = 1'b0;
    addressDataIn = 2'b00;
    burstSizeIn = 8'd0;
    step(2);
    chk("rst_grants", busGrants, 32'd0);
    chk("rst_err", 32'(busErrorOut), 32'd0);
    chk("rst_eot", 32'(endTransactionOut), 32'd0);
    chk("rst_idle", 32'(busIdle), 32'd1);
    chk("rst_snoop", 32'(snoopableBurst), 32'd0);
    reset = 1'b1;
    step(1);

    // Single master, late data then end.
    c = cyc;
    busRequests = 32'h8000_0000;
    push(32'h8000_0000, 1'b0, 1'b0, c + 1);
    step(1);
    chk("t1_idle_in_grant", 32'(busIdle), 32'd0);
    busRequests = '0;
    step(1);
    b = cyc;
    beginTransactionIn = 1'b1;
    addressDataIn = 2'b00;
    burstSizeIn = 8'd0;
    step(1);
    beginTransactionIn = 1'b0;
    chk("t1_snoop_zero_burst", 32'(snoopableBurst), 32'd0);
    step(19);
    dataValidIn = 1'b1;
    step(1);
    dataValidIn = 1'b0;
    step(2);
    endTransactionIn = 1'b1;
    chk("t1_busy_before_end", 32'(busIdle), 32'd0);
    step(1);
    endTransactionIn = 1'b0;
    chk("t1_idle_after_end", 32'(busIdle), 32'd1);

    // Priority: 17 beats 3, then 3 after a gap cycle.
    c = cyc;
    busRequests = 32'h0002_0008;
    push(32'h0002_0000, 1'b0, 1'b0, c + 1);
    step(1);
    busRequests = 32'h0000_0008;
    step(1);
    beginTransactionIn = 1'b1;
    step(1);
    beginTransactionIn = 1'b0;
    endTransactionIn = 1'b1;
    push(32'h0000_0008, 1'b0, 1'b0, c + 5);
    step(1);
    endTransactionIn = 1'b0;
    chk("t2_gap_idle", 32'(busIdle), 32'd1);
    step(1);
    busRequests = '0;
    step(1);
    beginTransactionIn = 1'b1;
    step(1);
    beginTransactionIn = 1'b0;
    endTransactionIn = 1'b1;
    step(1);
    endTransactionIn = 1'b0;
    chk("t2_idle_after_second", 32'(busIdle), 32'd1);

    // Watchdog in BUSY: error TO cycles after begin, end pulse next.
    c = cyc;
    busRequests = 32'h0000_0020;
    push(32'h0000_0020, 1'b0, 1'b0, c + 1);
    step(1);
    busRequests = '0;
    step(1);
    b = cyc;
    beginTransactionIn = 1'b1;
    push(32'd0, 1'b1, 1'b0, b + TO);
    push(32'd0, 1'b0, 1'b1, b + TO + 1);
    step(1);
    beginTransactionIn = 1'b0;
    step(TO - 1);
    chk("t3_not_idle_in_error", 32'(busIdle), 32'd0);
    step(2);
    chk("t3_idle_after_abort", 32'(busIdle), 32'd1);

    // End on the same edge as expiry: clean end, no error.
    c = cyc;
    busRequests = 32'h0000_0040;
    push(32'h0000_0040, 1'b0, 1'b0, c + 1);
    step(1);
    busRequests = '0;
    step(1);
    b = cyc;
    beginTransactionIn = 1'b1;
    step(1);
    beginTransactionIn = 1'b0;
    step(TO - 2);
    chk("t4_busy_at_limit", 32'(busIdle), 32'd0);
    endTransactionIn = 1'b1;
    step(1);
    endTransactionIn = 1'b0;
    chk("t4_end_wins", 32'(busIdle), 32'd1);
    step(3);

    // Watchdog in WAIT_BEGIN with the request still held.
    c = cyc;
    busRequests = 32'h0010_0000;
    push(32'h0010_0000, 1'b0, 1'b0, c + 1);
    push(32'd0, 1'b1, 1'b0, c + TO + 1);
    push(32'd0, 1'b0, 1'b1, c + TO + 2);
    step(TO + 1);
    busRequests = '0;
    step(2);
    chk("t5_idle_after_wait_abort", 32'(busIdle), 32'd1);

    // Snoopable burst in the snooped region.
    c = cyc;
    busRequests = 32'h0000_0200;
    push(32'h0000_0200, 1'b0, 1'b0, c + 1);
    step(1);
    busRequests = '0;
    step(1);
    beginTransactionIn = 1'b1;
    addressDataIn = 2'b00;
    burstSizeIn = 8'd7;
    step(1);
    beginTransactionIn = 1'b0;
    addressDataIn = 2'b00;
    burstSizeIn = 8'd0;
    for (int i = 0; i < 5; i++) begin
      chk("t6_snoop_busy", 32'(snoopableBurst), 32'd1);
      step(1);
    end
    endTransactionIn = 1'b1;
    step(1);
    endTransactionIn = 1'b0;
    chk("t6_snoop_cleared", 32'(snoopableBurst), 32'd0);

    // Burst outside the snooped region.
    c = cyc;
    busRequests = 32'h0000_0200;
    push(32'h0000_0200, 1'b0, 1'b0, c + 1);
    step(1);
    busRequests = '0;
    step(1);
    beginTransactionIn = 1'b1;
    addressDataIn = 2'b01;
    burstSizeIn = 8'd7;
    step(1);
    beginTransactionIn = 1'b0;
    addressDataIn = 2'b00;
    burstSizeIn = 8'd0;
    chk("t6b_snoop_other_region", 32'(snoopableBurst), 32'd0);
    endTransactionIn = 1'b1;
    step(1);
    endTransactionIn = 1'b0;

    // Abandon: request dropped with no begin.
    c = cyc;
    busRequests = 32'h0000_1000;
    push(32'h0000_1000, 1'b0, 1'b0, c + 1);
    step(1);
    busRequests = '0;
    step(1);
    chk("t7_waiting", 32'(busIdle), 32'd0);
    step(1);
    chk("t7_abandon_idle", 32'(busIdle), 32'd1);
    step(3);

    // Reset in BUSY with a snoopable burst live.
    c = cyc;
    busRequests = 32'h0000_0004;
    push(32'h0000_0004, 1'b0, 1'b0, c + 1);
    step(1);
    busRequests = '0;
    step(1);
    beginTransactionIn = 1'b1;
    burstSizeIn = 8'd3;
    step(1);
    beginTransactionIn = 1'b0;
    burstSizeIn = 8'd0;
    step(1);
    chk("t8_snoop_before_rst", 32'(snoopableBurst), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("t8_rst_grants", busGrants, 32'd0);
    chk("t8_rst_err", 32'(busErrorOut), 32'd0);
    chk("t8_rst_eot", 32'(endTransactionOut), 32'd0);
    chk("t8_rst_idle", 32'(busIdle), 32'd1);
    chk("t8_rst_snoop", 32'(snoopableBurst), 32'd0);
    step(1);
    reset = 1'b1;
    step(1);
    c = cyc;
    busRequests = 32'h0000_0001;
    push(32'h0000_0001, 1'b0, 1'b0, c + 1);
    step(1);
    busRequests = '0;
    step(4);
    chk("t8_idle_after_regrant", 32'(busIdle), 32'd1);

    chk("all_events_seen", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
